// File: rtl/palette_colorizer.sv
// palette_colorizer: double-buffered palette lookup turning world/icon codes into registered RGB.
// Ports:
//   clk, reset_n              pixel clock, asynchronous active-low reset
//   video_on, world_pixel,
//   icon, frame_start         current pixel inputs and vertical-blank commit pulse
//   pal_wr_valid/ready/addr/
//   data, pal_wr_err          palette write port into the shadow bank, error pulse on bad address
//   vgaRed/Green/Blue,
//   video_on_q                colour and display-enable, two cycles after the pixel inputs
module palette_colorizer #(
    parameter int COLOR_W      = 4,
    parameter int WORLD_W      = 2,
    parameter int ICON_W       = 2,
    parameter int BLINK_FRAMES = 30,
    localparam int NW = 2 ** WORLD_W,
    localparam int NI = 2 ** ICON_W,
    localparam int AW = $clog2(NW + NI),
    localparam int DW = 3 * COLOR_W + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               video_on,
    input  logic [WORLD_W-1:0] world_pixel,
    input  logic [ICON_W-1:0]  icon,
    input  logic               frame_start,
    input  logic               pal_wr_valid,
    output logic               pal_wr_ready,
    input  logic [AW-1:0]      pal_wr_addr,
    input  logic [DW-1:0]      pal_wr_data,
    output logic               pal_wr_err,
    output logic [COLOR_W-1:0] vgaRed,
    output logic [COLOR_W-1:0] vgaGreen,
    output logic [COLOR_W-1:0] vgaBlue,
    output logic               video_on_q
);
    localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    // Left-align a 4-bit default nibble and repeat it into any remaining low bits.
    function automatic logic [COLOR_W-1:0] expand(input logic [3:0] n);
        logic [COLOR_W-1:0] c;
        c = '0;
        for (int i = 0; i < COLOR_W; i++) c[COLOR_W-1-i] = n[3-(i%4)];
        return c;
    endfunction

    function automatic logic [DW-1:0] default_entry(input int idx);
        logic [11:0] h;
        h = idx < NW ? ((idx % 4 == 2) ? 12'h485 : (idx % 4 == 1) ? 12'h986 : 12'h8B5)
                     : (((idx - NW) % 4 == 3) ? 12'hFFF : ((idx - NW) % 4 == 2) ? 12'hF00 : 12'h000);
        return {1'b0, expand(h[11:8]), expand(h[7:4]), expand(h[3:0])};
    endfunction

    logic [DW-1:0]      shadow [NW+NI];
    logic [DW-1:0]      active [NW+NI];
    logic [CW-1:0]      blink_cnt;
    logic               blink_phase;
    logic               s1_von;
    logic [WORLD_W-1:0] s1_world;
    logic [ICON_W-1:0]  s1_icon;
    logic               wr_ok;
    logic               addr_bad;
    logic               addr_world;
    logic [DW-1:0]      wr_entry;
    logic [DW-1:0]      world_e;
    logic [DW-1:0]      icon_e;
    logic               show_icon;
    logic [3*COLOR_W-1:0] pix;

    assign pal_wr_ready = !frame_start;
    assign wr_ok        = pal_wr_valid && pal_wr_ready;
    assign addr_world   = int'(pal_wr_addr) < NW;
    assign addr_bad     = int'(pal_wr_addr) == NW || int'(pal_wr_addr) >= NW + NI;
    // World entries never blink, so their blink bit is forced clear on the way in.
    assign wr_entry     = addr_world ? {1'b0, pal_wr_data[DW-2:0]} : pal_wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NW + NI; i++) begin
                shadow[i] <= default_entry(i);
                active[i] <= default_entry(i);
            end
        end else begin
            if (frame_start)
                for (int i = 0; i < NW + NI; i++) active[i] <= shadow[i];
            if (wr_ok && !addr_bad)
                shadow[pal_wr_addr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            blink_cnt   <= blink_cnt == CW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
            blink_phase <= blink_cnt == CW'(BLINK_FRAMES - 1) ? !blink_phase : blink_phase;
        end
    end

    // Lookup happens in stage 2, so a commit on frame_start already applies to the
    // pixel presented in that same cycle.
    always_comb begin
        world_e   = active[AW'(s1_world)];
        icon_e    = active[AW'(NW) + AW'(s1_icon)];
        show_icon = s1_icon != '0 && !(icon_e[DW-1] && !blink_phase);
        pix       = !s1_von ? '0 : show_icon ? icon_e[DW-2:0] : world_e[DW-2:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_von     <= 1'b0;
            s1_world   <= '0;
            s1_icon    <= '0;
            vgaRed     <= '0;
            vgaGreen   <= '0;
            vgaBlue    <= '0;
            video_on_q <= 1'b0;
            pal_wr_err <= 1'b0;
        end else begin
            s1_von     <= video_on;
            s1_world   <= world_pixel;
            s1_icon    <= icon;
            {vgaRed, vgaGreen, vgaBlue} <= pix;
            video_on_q <= s1_von;
            pal_wr_err <= wr_ok && addr_bad;
        end
    end
endmodule

// File: tb/tb_palette_colorizer.sv
// tb_palette_colorizer: scoreboard bench for palette_colorizer against a bank/frame-count model.
module tb_palette_colorizer;
    localparam int CW = 4, WW = 2, IW = 2, BF = 2, NW = 4, NI = 4, AW = 3, DW = 13;

    typedef struct { int due; logic [12:0] exp; } pix_t;
    typedef struct { int due; logic exp; } err_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          video_on = 1'b0;
    logic [WW-1:0] world_pixel = '0;
    logic [IW-1:0] icon = '0;
    logic          frame_start = 1'b0;
    logic          pal_wr_valid = 1'b0;
    logic          pal_wr_ready;
    logic [AW-1:0] pal_wr_addr = '0;
    logic [DW-1:0] pal_wr_data = '0;
    logic          pal_wr_err;
    logic [CW-1:0] vgaRed, vgaGreen, vgaBlue;
    logic          video_on_q;

    int tests = 0, fails = 0, cyc = 0, frames = 0;
    pix_t pix_q[$];
    err_t err_q[$];
    logic [12:0] shadow_m [8];
    logic [12:0] active_m [8];

    palette_colorizer #(.COLOR_W(CW), .WORLD_W(WW), .ICON_W(IW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on), .world_pixel(world_pixel),
        .icon(icon), .frame_start(frame_start), .pal_wr_valid(pal_wr_valid),
        .pal_wr_ready(pal_wr_ready), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
        .pal_wr_err(pal_wr_err), .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .video_on_q(video_on_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void reset_model();
        logic [11:0] wdef [4];
        logic [11:0] idef [4];
        wdef = '{12'h8B5, 12'h986, 12'h485, 12'h8B5};
        idef = '{12'h000, 12'h000, 12'hF00, 12'hFFF};
        for (int i = 0; i < 4; i++) begin
            shadow_m[i] = {1'b0, wdef[i]};
            shadow_m[NW+i] = {1'b0, idef[i]};
        end
        active_m = shadow_m;
        frames = 0;
    endfunction

    // Blink phase starts at 1 and flips after every BF frame_start pulses.
    function automatic logic [12:0] expect_pixel(input logic von, input int w, input int ic);
        logic phase;
        logic [12:0] e;
        phase = ((frames / BF) % 2) == 0;
        if (!von) return 13'h0;
        e = active_m[NW+ic];
        if (ic != 0 && !(e[12] && !phase)) return {1'b1, e[11:0]};
        return {1'b1, active_m[w][11:0]};
    endfunction

    task automatic step(input logic von, input int w, input int ic, input logic v,
                        input int a, input logic [12:0] d, input logic fs);
        logic acc, bad;
        @(posedge clk); #1;
        video_on = von; world_pixel = WW'(w); icon = IW'(ic);
        pal_wr_valid = v; pal_wr_addr = AW'(a); pal_wr_data = d; frame_start = fs;
        #1;
        tests++;
        if (pal_wr_ready !== !fs) begin
            fails++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, pal_wr_ready, !fs);
        end
        acc = v && !fs;
        bad = a == NW || a >= NW + NI;
        if (fs) begin
            active_m = shadow_m;
            frames++;
        end
        if (acc && !bad) shadow_m[a] = a < NW ? {1'b0, d[11:0]} : d;
        err_q.push_back('{cyc + 1, acc && bad});
        pix_q.push_back('{cyc + 2, expect_pixel(von, w, ic)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            video_on = 0; pal_wr_valid = 0; frame_start = 0;
        end
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        tests++;
        if ({video_on_q, vgaRed, vgaGreen, vgaBlue, pal_wr_err} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", {video_on_q, vgaRed, vgaGreen, vgaBlue, pal_wr_err});
        end
        tests++;
        if (pal_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got=%b exp=1", pal_wr_ready);
        end
    endtask

    always @(negedge clk) begin
        while (pix_q.size() != 0 && pix_q[0].due <= cyc) begin
            pix_t p;
            p = pix_q.pop_front();
            tests++;
            if (p.due != cyc || {video_on_q, vgaRed, vgaGreen, vgaBlue} !== p.exp) begin
                fails++;
                $display("FAIL pixel cyc=%0d due=%0d got=%h exp=%h", cyc, p.due,
                         {video_on_q, vgaRed, vgaGreen, vgaBlue}, p.exp);
            end
        end
        while (err_q.size() != 0 && err_q[0].due <= cyc) begin
            err_t e;
            e = err_q.pop_front();
            tests++;
            if (e.due != cyc || pal_wr_err !== e.exp) begin
                fails++;
                $display("FAIL wr_err cyc=%0d due=%0d got=%b exp=%b", cyc, e.due, pal_wr_err, e.exp);
            end
        end
    end

    initial begin
        logic hv, v, fs;
        int ha, a;
        logic [12:0] hd, d;
        reset_model();
        repeat (3) @(posedge clk);
        check_reset_outputs();
        @(posedge clk); #1 reset_n = 1'b1;
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0, 0);
        step(1, 0, 1, 1, 5, 13'h00F0, 0);
        step(1, 3, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 3, 1, 0, 0, 0, 0);
        step(1, 0, 2, 1, 6, 13'h000F, 1);
        step(1, 0, 2, 1, 6, 13'h000F, 0);
        step(1, 0, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 2, 0, 0, 0, 0);
        step(1, 2, 0, 1, 4, 13'h1ABC, 0);
        step(1, 2, 0, 1, 1, 13'h1123, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 3, 1, 7, 13'h1FFF, 0);
        for (int f = 0; f < 9; f++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            for (int k = 0; k < 3; k++) step(1, 2, 3, 0, 0, 0, 0);
        end
        step(1, 0, 2, 1, 6, 13'h00F0, 0);
        idle(4);
        #2 reset_n = 1'b0;
        reset_model();
        check_reset_outputs();
        @(posedge clk); #1 reset_n = 1'b1;
        step(1, 0, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 2, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0);
        hv = 0; ha = 0; hd = 0;
        for (int i = 0; i < 3000; i++) begin
            fs = $urandom_range(0, 15) == 0;
            if (hv) begin
                v = 1; a = ha; d = hd;
            end else begin
                v = $urandom_range(0, 2) == 0; a = $urandom_range(0, 7); d = 13'($urandom);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), v, a, d, fs);
            hv = v && fs; ha = a; hd = d;
        end
        idle(4);
        tests++;
        if (pix_q.size() != 0 || err_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d exp=0", pix_q.size() + err_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/palette_colorizer.md
PALETTE_COLORIZER -- requirements
Module: palette_colorizer

Interface
REQ-001 Parameter COLOR_W, default 4, bits per colour channel.
REQ-002 Parameter WORLD_W, default 2, width of world_pixel code.
REQ-003 Parameter ICON_W, default 2, width of icon code; code 0 = transparent.
REQ-004 Parameter BLINK_FRAMES, default 30, frames per blink half-period (>=1).
REQ-005 Derived: NW = 2^WORLD_W world entries, NI = 2^ICON_W icon entries, AW = clog2(NW+NI).
REQ-006 clk  in  1  pixel clock; one clock domain, all logic rising-edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 video_on  in  1  display-enable for current pixel.
REQ-009 world_pixel  in  WORLD_W  map code for current pixel.
REQ-010 icon  in  ICON_W  icon code for current pixel.
REQ-011 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-012 pal_wr_valid  in  1  palette write request.
REQ-013 pal_wr_ready  out  1  palette write accept.
REQ-014 pal_wr_addr  in  AW  entry index: 0..NW-1 world, NW+k icon code k.
REQ-015 pal_wr_data  in  3*COLOR_W+1  {blink, R, G, B}.
REQ-016 pal_wr_err  out  1  one-cycle pulse on accepted write to invalid address.
REQ-017 vgaRed, vgaGreen, vgaBlue  out  COLOR_W each  registered pixel colour.
REQ-018 video_on_q  out  1  video_on delayed to align with colour outputs.

Function
REQ-019 Pixel path SHALL be a 2-stage pipeline: stage 1 registers video_on, world_pixel, icon; stage 2 registers colour; latency exactly 2 cycles, throughput 1 pixel/cycle.
REQ-020 video_on_q SHALL equal video_on delayed 2 cycles.
REQ-021 Stage-1 video_on=0 SHALL produce colour 0 (black) at stage 2.
REQ-022 Icon code k!=0 visible SHALL select active icon entry k; otherwise active world entry for world_pixel.
REQ-023 Icon code k!=0 SHALL be treated as transparent when its active blink bit=1 and blink phase=0.
REQ-024 Palette SHALL be double-buffered: writes update shadow bank; active bank used for lookup.
REQ-025 Write accepted when pal_wr_valid && pal_wr_ready; shadow entry updated on that edge.
REQ-026 pal_wr_ready SHALL be 1 except in cycles where frame_start=1 (commit cycle).
REQ-027 On frame_start, full shadow bank SHALL copy to active bank in one cycle; new colours visible from the first pixel after commit.
REQ-028 Writes to address NW (icon 0) or >= NW+NI SHALL be accepted, discarded, and pulse pal_wr_err the next cycle.
REQ-029 Blink bit on world entries SHALL be stored as 0.
REQ-030 Blink counter SHALL count frame_start pulses 0..BLINK_FRAMES-1, wrap to 0, and toggle blink phase on wrap.
REQ-031 Valid and frame_start in same cycle: write not accepted (ready=0), master holds request; commit uses prior shadow contents.
REQ-032 Consecutive accepted writes to same address: last write wins.

Reset
REQ-033 Asynchronous assertion SHALL clear pipeline registers, colour outputs, video_on_q, pal_wr_err, blink counter; blink phase=1.
REQ-034 Both banks SHALL reset to defaults (COLOR_W=4 values; other widths: nibble left-aligned, repeated into low bits): world 0=8B5, 1=986, 2=485, 3=8B5; icon 1=000, 2=F00, 3=FFF; all blink=0.
REQ-035 Reset mid-frame SHALL discard pending shadow writes; pal_wr_ready=1 from first edge after deassert.

Verification
REQ-036 After reset, video_on=1, world=1, icon=0 -> RGB=9,8,6 two cycles later, video_on_q=1.
REQ-037 video_on=0, icon=2 -> RGB=0,0,0 at +2 cycles; icon=2 video_on=1 -> F,0,0.
REQ-038 Write addr 5 (icon 1) data {0,0x0F0}, no frame_start -> icon 1 still 000; after frame_start pulse -> 0F0.
REQ-039 pal_wr_valid with frame_start same cycle -> ready=0, no write; held next cycle -> accepted, visible only after following frame_start.
REQ-040 Write icon 3 blink=1, commit, BLINK_FRAMES=2: icon=3 world=2 -> FFF for 2 frames, 485 next 2 frames, repeating.
REQ-041 Write addr 4 -> pal_wr_err pulse 1 cycle, palette unchanged; reset during pending shadow write -> defaults restored.
